mips_inst_encoder: RTL and testbench
====================================

# mips_inst_encoder

Instruction encoder and program loader for the pipelined MIPS core. It accepts one symbolic instruction per handshake (mnemonic select plus register, shift, immediate and target fields) and packs it into the 32-bit MIPS word that the core's control decoder consumes. It then writes that word into instruction memory at an auto-incrementing word address. Benches and boot logic use it to build programs without hand-assembling hex.

## Interface
Parameters:
- ADDR_W, 8, width of the instruction-memory word address; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first write after reset or `start`.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  synchronous clear of pointer, count, `full` and `err_op`.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept; combinational: `!full && !start`.
- in_op  in  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 ADDI, 12 J; 13–15 are invalid.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  I-type immediate or offset.
- in_target  in  26  J-type target.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written since reset or `start`.
- full  out  1  set when `count` equals 2^ADDR_W.
- err_op  out  1  sticky; set when an invalid `in_op` is accepted.

## Operation
Handshake:
- A transfer occurs on a rising edge where `in_valid && in_ready`.
- Inputs are sampled only on a transfer.
- `in_valid` may drop without a transfer; nothing is latched.

Encoding, registered into `imem_wdata` on the transfer edge:
- R-type:
  - word = {6'h00, rs, rt, rd, shamt, funct}.
  - funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, SLL 0x00, SRL 0x02.
  - SLL/SRL force the rs field to 0.
  - All other R-types force the shamt field to 0.
- I-type:
  - word = {opcode, rs, rt, imm}.
  - opcode: LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08.
  - rd and shamt inputs are ignored.
- J:
  - word = {6'h02, target}.

Invalid op:
- The transfer is consumed and `err_op` is set.
- No write occurs: `imem_we` stays 0.
- `count` and the pointer are unchanged.

Pointer and count:
- After each valid transfer, `imem_addr` holds the internal pointer and `imem_we` pulses for one cycle.
- The pointer increments modulo 2^ADDR_W and `count` increments by 1, both on the transfer edge.
- `full` is combinational from `count`.

FSM states:
- LOAD: `full`=0. Stay in LOAD while `count` < 2^ADDR_W after an increment.
- FULL: `full`=1, `in_ready`=0. Entered when `count` reaches 2^ADDR_W. Left only via `start` or `rst`.

`start`:
- Has priority over any transfer in the same cycle; no transfer occurs because `in_ready` is 0.
- Next edge: pointer = BASE_ADDR, `count`=0, `full`=0, `err_op`=0.
- An `imem_we` pulse already issued from the previous cycle still completes.

Reset values (asynchronous):
- `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0, `count`=0, `full`=0, `err_op`=0.
- FSM in LOAD.

## Timing
- Latency: a transfer at edge N produces `imem_we`=1 with addr/data valid during cycle N+1 (one register stage).
- Throughput is one word per cycle; `in_ready` stays high back-to-back until `full`.
- The last write: the transfer that makes `count` = 2^ADDR_W drives `in_ready` low in the following cycle. Its `imem_we` pulse still occurs.
- Pointer wrap: after the write at address 2^ADDR_W−1 the pointer returns to 0, but no further transfer is possible until `start`.
- `rst` during an `imem_we` pulse clears the strobe immediately; that write is lost.
- An invalid op in the cycle that would otherwise fill the memory does not set `full`.

## Test plan
- Reset, then ADD rs=1 rt=2 rd=3 -> next cycle `imem_we`=1, `imem_addr`=0, `imem_wdata`=0x00221820, `count`=1.
- Back-to-back LW rs=29 rt=8 imm=4, then J target=0x10 -> data 0x8FA80004 @0, then 0x08000010 @1, on consecutive cycles.
- SLL rs=7 rt=1 rd=2 shamt=4 -> 0x00011100 (rs forced 0); SUB with shamt=5 -> shamt field 0.
- ADDR_W=2: four valid transfers -> `count`=4, `full`=1, `in_ready`=0, pointer back to 0. Then `start` -> `count`=0, `in_ready`=1, and the next write lands at address 0.
- in_op=14 -> `err_op`=1, no `imem_we`, `count` unchanged. A following valid op still writes, and `err_op` stays 1 until `start`.
- Assert `rst` asynchronously while `imem_we`=1 -> `imem_we`, `count`, `imem_wdata` drop to 0 before the next edge.

Source files
------------

// File: rtl/mips_inst_encoder.sv
// Packs symbolic MIPS instructions into 32-bit words and streams them into
// instruction memory at an auto-incrementing word address.
//
// state  | meaning
// S_LOAD | accepting instructions, memory not yet full
// S_FULL | 2^ADDR_W words written; only start or rst leaves
module mips_inst_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_op
);

  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_SLT = 4'd4, OP_SLL = 4'd5,
                         OP_SRL = 4'd6, OP_LW  = 4'd7, OP_SW  = 4'd8,
                         OP_BEQ = 4'd9, OP_BNE = 4'd10, OP_ADDI = 4'd11,
                         OP_J   = 4'd12;

  typedef enum logic {S_LOAD, S_FULL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] word;
  logic        op_valid;
  logic        xfer;

  always_comb begin
    word     = '0;
    op_valid = 1'b1;
    case (in_op)
      OP_ADD:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      OP_SUB:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      OP_AND:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      OP_OR:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      OP_SLT:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      // shifts take their amount from shamt, so rs is meaningless and zeroed
      OP_SLL:  word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
      OP_SRL:  word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h02};
      OP_LW:   word = {6'h23, in_rs, in_rt, in_imm};
      OP_SW:   word = {6'h2B, in_rs, in_rt, in_imm};
      OP_BEQ:  word = {6'h04, in_rs, in_rt, in_imm};
      OP_BNE:  word = {6'h05, in_rs, in_rt, in_imm};
      OP_ADDI: word = {6'h08, in_rs, in_rt, in_imm};
      OP_J:    word = {6'h02, in_target};
      default: op_valid = 1'b0;
    endcase
  end

  assign in_ready = (state_q == S_LOAD) && !start;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start) begin
      state_d = S_LOAD;
      ptr_d   = BASE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (xfer) begin
      if (op_valid) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = word;
        ptr_d   = ptr_q + ADDR_W'(1);
        cnt_d   = cnt_q + (ADDR_W+1)'(1);
        if (cnt_d == CAP) state_d = S_FULL;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      ptr_q   <= BASE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = cnt_q;
  assign full       = (cnt_q == CAP);
  assign err_op     = err_q;

endmodule

// File: tb/tb_mips_inst_encoder.sv
// Bench for mips_inst_encoder (ADDR_W=2): vector table plus write scoreboard,
// with hand-written sequences for fill, invalid op, start and async reset.
module tb_mips_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0]  count;
  logic        full;
  logic        err_op;

  mips_inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .full(full), .err_op(err_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  wr_t        sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] m_ptr = '0;
  int         m_cnt = 0;
  logic       m_full = 1'b0;
  logic       m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sb_q.size() == 0) begin
        chk("write_strobe_idle", 32'(imem_we), 32'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("write_strobe", 32'(imem_we), 32'd1);
        chk("write_addr", 32'(imem_addr), 32'(e.addr));
        chk("write_data", imem_wdata, e.data);
      end
      chk("count", 32'(count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_full));
      chk("err_op", 32'(err_op), 32'(m_err));
      chk("in_ready", 32'(in_ready), 32'(!m_full && !start));
    end
  end

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] exp);
    @(negedge clk);
    #1;
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
    @(posedge clk);
    if (!m_full) begin
      if (op <= 4'd12) begin
        sb_q.push_back('{m_ptr, exp});
        m_ptr++;
        m_cnt++;
        m_full = (m_cnt == 4);
      end else begin
        m_err = 1'b1;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    m_ptr = '0; m_cnt = 0; m_full = 1'b0; m_err = 1'b0;
    #1 start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h00221820};
    vecs[1]  = '{4'd1,  5'd1,  5'd2,  5'd3,  5'd5,  16'h0000, 26'h0,       32'h00221822};
    vecs[2]  = '{4'd2,  5'd4,  5'd5,  5'd6,  5'd0,  16'h0000, 26'h0,       32'h00853024};
    vecs[3]  = '{4'd3,  5'd31, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       32'h03FFF825};
    vecs[4]  = '{4'd4,  5'd8,  5'd9,  5'd10, 5'd0,  16'h0000, 26'h0,       32'h0109502A};
    vecs[5]  = '{4'd5,  5'd7,  5'd1,  5'd2,  5'd4,  16'h0000, 26'h0,       32'h00011100};
    vecs[6]  = '{4'd6,  5'd3,  5'd4,  5'd5,  5'd31, 16'h0000, 26'h0,       32'h00042FC2};
    vecs[7]  = '{4'd7,  5'd29, 5'd8,  5'd0,  5'd0,  16'h0004, 26'h0,       32'h8FA80004};
    vecs[8]  = '{4'd8,  5'd29, 5'd31, 5'd7,  5'd3,  16'hFFFC, 26'h0,       32'hAFBFFFFC};
    vecs[9]  = '{4'd15, 5'd1,  5'd1,  5'd1,  5'd1,  16'h1111, 26'h1,       32'h00000000};
    vecs[10] = '{4'd9,  5'd1,  5'd2,  5'd0,  5'd0,  16'h0003, 26'h0,       32'h10220003};
    vecs[11] = '{4'd10, 5'd3,  5'd0,  5'd0,  5'd0,  16'h8000, 26'h0,       32'h14608000};
    vecs[12] = '{4'd11, 5'd0,  5'd5,  5'd9,  5'd0,  16'h1234, 26'h0,       32'h20051234};
    vecs[13] = '{4'd12, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};

    // reset values while rst is held
    #12;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err_op), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    idle(1);

    for (int i = 0; i < 14; i++) begin
      if (m_full) do_start();
      send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
           vecs[i].imm, vecs[i].tgt, vecs[i].exp);
    end
    idle(2);

    // back-to-back LW then J from a fresh start
    do_start();
    send(4'd7, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8FA80004);
    send(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 32'h08000010);
    idle(2);

    // invalid op on the would-be filling transfer, then fill, then blocked attempt
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820);
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820);
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820);
    send(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0);
    send(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h2A, 32'h0800002A);
    idle(1);
    #2;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_err_sticky", 32'(err_op), 32'd1);
    send(4'd0, 5'd9, 5'd9, 5'd9, 5'd0, 16'h0, 26'h0, 32'h0);
    idle(2);
    do_start();
    send(4'd2, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h00853024);
    idle(2);

    // async reset while a write strobe is high
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820);
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(imem_we), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_wdata", imem_wdata, 32'd0);
    sb_q.delete();
    m_ptr = '0; m_cnt = 0; m_full = 1'b0; m_err = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    send(4'd11, 5'd0, 5'd5, 5'd9, 5'd0, 16'h1234, 26'h0, 32'h20051234);
    idle(3);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
